// File: rtl/tape_recorder.sv
// tape_recorder: cassette-write encoder for the PET core.
// Measures the interval between falling edges of cass_write in CPU cycles
// (ce_1m ticks, frozen while the motor is off) and writes it to memory as a
// TAP v1 pulse stream through an ack-paced byte write port.
//
// Build option: define TAPE_REC_HEADER_EN to emit the 20-byte TAP header
// ("C64-TAPE-RAW", version, reserved, little-endian length patched at the
// end). Without it the raw pulse stream starts at BASE_ADDR+0.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   ce_1m                  CPU clock enable, one tick per PET cycle
//   rec                    recording level (rise starts, fall stops)
//   cass_write             PET cassette write line
//   cass_motor_n           motor control, 0 = on; counter frozen while high
//   mem_addr/mem_dout      write byte address / data
//   mem_we / mem_ack       write request held until the single-cycle ack
//   busy                   recording, drain or length patch in progress
//   length                 pulse-data bytes written in current/last recording
//   overflow               sticky: one or more pulses were dropped
module tape_recorder #(
    parameter logic [24:0] BASE_ADDR  = 25'h0,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_1m,
    input  logic        rec,
    input  logic        cass_write,
    input  logic        cass_motor_n,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        busy,
    output logic [23:0] length,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef TAPE_REC_HEADER_EN
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd3;

    function automatic logic [7:0] hdr_byte(input logic [3:0] i);
        case (i)
            4'd0:    hdr_byte = 8'h43;  // C
            4'd1:    hdr_byte = 8'h36;  // 6
            4'd2:    hdr_byte = 8'h34;  // 4
            4'd3:    hdr_byte = 8'h2D;  // -
            4'd4:    hdr_byte = 8'h54;  // T
            4'd5:    hdr_byte = 8'h41;  // A
            4'd6:    hdr_byte = 8'h50;  // P
            4'd7:    hdr_byte = 8'h45;  // E
            4'd8:    hdr_byte = 8'h2D;  // -
            4'd9:    hdr_byte = 8'h52;  // R
            4'd10:   hdr_byte = 8'h41;  // A
            4'd11:   hdr_byte = 8'h57;  // W
            4'd12:   hdr_byte = 8'h01;  // TAP version 1
            default: hdr_byte = 8'h00;
        endcase
    endfunction
`endif

    // ---------------- input edge detection ----------------
    logic cw_q, cw_prev_q, rec_q;
    logic fall, rec_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cw_q      <= 1'b1;
            cw_prev_q <= 1'b1;
            rec_q     <= 1'b0;
        end else begin
            cw_q      <= cass_write;
            cw_prev_q <= cw_q;
            rec_q     <= rec;
        end
    end

    assign fall     = cw_prev_q & ~cw_q;
    assign rec_rise = rec & ~rec_q;

    // ---------------- interval measurement ----------------
    logic        act_q;     // measurement window open (rec held since accepted rise)
    logic        armed_q;
    logic [23:0] cnt_q;
    logic        push, push_long;
    logic [7:0]  short_v;
    logic [24:0] push_data;

    assign push      = act_q & armed_q & fall;
    assign push_long = |cnt_q[23:11];
    assign short_v   = (cnt_q[10:3] == 8'd0) ? 8'd1 : cnt_q[10:3];
    assign push_data = push_long ? {1'b1, cnt_q} : {1'b0, 16'h0, short_v};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
            cnt_q   <= 24'd0;
        end else if (!act_q) begin
            // Closing the window throws away any partial interval.
            armed_q <= 1'b0;
            cnt_q   <= 24'd0;
        end else if (fall) begin
            armed_q <= 1'b1;
            cnt_q   <= {23'd0, ce_1m};  // the tick in the edge cycle opens the new interval
        end else if (armed_q && ce_1m && !cass_motor_n && cnt_q != 24'hFFFFFF) begin
            cnt_q   <= cnt_q + 24'd1;
        end
    end

    // ---------------- pulse FIFO ----------------
    logic [24:0] fifo_q [FIFO_DEPTH];
    logic [AW:0] wp_q, rp_q;
    logic        empty, full, pop, push_ok, drop;
    logic [24:0] head;

    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign head    = fifo_q[rp_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wp_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push_ok) wp_q <= wp_q + PTR_ONE;
            if (pop)     rp_q <= rp_q + PTR_ONE;
        end
    end

    // ---------------- byte writer ----------------
    logic [2:0]  state_q;
    logic        we_q, ovf_q;
    logic [24:0] addr_q;
    logic [7:0]  dout_q;
    logic [3:0]  idx_q;     // header / data / length byte index
    logic [23:0] len_q;
    logic        head_long, last_byte, fits;
    logic [7:0]  data_byte;

    assign head_long = head[24];
    assign last_byte = !head_long || (idx_q[1:0] == 2'd3);
    assign fits      = head_long ? (len_q <= 24'hFFFFFB) : (len_q != 24'hFFFFFF);

    // The head entry stays in the FIFO until its last byte is acknowledged,
    // so the entry being written still occupies a slot.
    assign pop = (state_q == S_DATA) && !empty &&
                 ((we_q && mem_ack && last_byte) ||
                  (!we_q && idx_q == 4'd0 && !fits));

    always_comb begin
        data_byte = head[7:0];
        if (head_long) begin
            case (idx_q[1:0])
                2'd0:    data_byte = 8'h00;
                2'd1:    data_byte = head[7:0];
                2'd2:    data_byte = head[15:8];
                default: data_byte = head[23:16];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            dout_q  <= 8'h00;
            idx_q   <= 4'd0;
            len_q   <= 24'd0;
            ovf_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            if (!rec)
                act_q <= 1'b0;
            else if (state_q == S_IDLE && rec_rise)
                act_q <= 1'b1;

            case (state_q)
                S_IDLE: if (rec_rise) begin
                    len_q  <= 24'd0;
                    ovf_q  <= 1'b0;
                    idx_q  <= 4'd0;
                    addr_q <= BASE_ADDR;
`ifdef TAPE_REC_HEADER_EN
                    state_q <= S_HDR;
`else
                    state_q <= S_DATA;
`endif
                end
`ifdef TAPE_REC_HEADER_EN
                S_HDR: begin
                    if (we_q) begin
                        if (mem_ack) begin
                            we_q <= 1'b0;
                            if (idx_q == 4'd15) begin
                                state_q <= S_DATA;
                                idx_q   <= 4'd0;
                                addr_q  <= BASE_ADDR + 25'd20;  // skip the length field
                            end else begin
                                idx_q  <= idx_q + 4'd1;
                                addr_q <= addr_q + 25'd1;
                            end
                        end
                    end else begin
                        we_q   <= 1'b1;
                        dout_q <= hdr_byte(idx_q);
                    end
                end
                S_LEN: begin
                    if (we_q) begin
                        if (mem_ack) begin
                            we_q   <= 1'b0;
                            addr_q <= addr_q + 25'd1;
                            if (idx_q == 4'd3) state_q <= S_DONE;
                            else               idx_q   <= idx_q + 4'd1;
                        end
                    end else begin
                        we_q <= 1'b1;
                        case (idx_q[1:0])
                            2'd0:    dout_q <= len_q[7:0];
                            2'd1:    dout_q <= len_q[15:8];
                            2'd2:    dout_q <= len_q[23:16];
                            default: dout_q <= 8'h00;
                        endcase
                    end
                end
`endif
                S_DATA: begin
                    if (we_q) begin
                        if (mem_ack) begin
                            we_q   <= 1'b0;
                            addr_q <= addr_q + 25'd1;
                            len_q  <= len_q + 24'd1;
                            idx_q  <= last_byte ? 4'd0 : idx_q + 4'd1;
                        end
                    end else if (!empty) begin
                        if (idx_q != 4'd0 || fits) begin
                            we_q   <= 1'b1;
                            dout_q <= data_byte;
                        end else begin
                            ovf_q  <= 1'b1;  // entry discarded by pop, no room left
                        end
                    end else if (!act_q) begin
`ifdef TAPE_REC_HEADER_EN
                        state_q <= S_LEN;
                        idx_q   <= 4'd0;
                        addr_q  <= BASE_ADDR + 25'd16;
`else
                        state_q <= S_DONE;
`endif
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            if (drop) ovf_q <= 1'b1;
        end
    end

    assign mem_addr = addr_q;
    assign mem_dout = dout_q;
    assign mem_we   = we_q;
    assign busy     = (state_q != S_IDLE);
    assign length   = len_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_tape_recorder.sv
// Self-checking bench for tape_recorder: drives falling-edge pulse trains,
// captures written bytes through an ack-delayed memory responder, and
// compares against TAP encodings computed from the interval lengths.
module tb_tape_recorder;

    localparam logic [24:0] BASE = 25'h100;
`ifdef TAPE_REC_HEADER_EN
    localparam int  DOFF = 20;
    localparam bit  HDR  = 1'b1;
`else
    localparam int  DOFF = 0;
    localparam bit  HDR  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, ce_1m, rec, cass_write, cass_motor_n, mem_ack;
    logic [24:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_we, busy, overflow;
    logic [23:0] length;

    tape_recorder #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m), .rec(rec),
        .cass_write(cass_write), .cass_motor_n(cass_motor_n),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we),
        .mem_ack(mem_ack), .busy(busy), .length(length), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    logic [7:0]  mem [int];
    int          nwr = 0;
    bit          ack_en = 1'b1;
    int          ce_div = 1;
    bit          ce_ph = 1'b0;
    logic [7:0]  exp_q [$];

    // Clock-enable generator: every clk, or every second clk.
    initial begin
        ce_1m = 1'b1;
        forever begin
            @(negedge clk);
            ce_ph = ~ce_ph;
            ce_1m = (ce_div == 1) ? 1'b1 : ce_ph;
        end
    end

    // Memory responder: acks a request 2 clk after it appears.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_we && ack_en && reset_n) begin
                if (wcnt >= 1) begin
                    mem_ack = 1'b1;
                    mem[int'(mem_addr - BASE)] = mem_dout;
                    nwr++;
                    wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    // TAP v1 encoding of one interval, from the format rules.
    function automatic void add_exp(input int t);
        logic [23:0] tv;
        logic [7:0]  v;
        tv = t[23:0];
        if (t < 2048) begin
            v = 8'(t / 8);
            if (v == 8'd0) v = 8'd1;
            exp_q.push_back(v);
        end else begin
            exp_q.push_back(8'h00);
            exp_q.push_back(tv[7:0]);
            exp_q.push_back(tv[15:8]);
            exp_q.push_back(tv[23:16]);
        end
    endfunction

    function automatic logic [7:0] rd(input int k);
        rd = mem.exists(k) ? mem[k] : 8'hxx;
    endfunction

    task automatic clear_rec();
        mem.delete();
        nwr = 0;
        exp_q.delete();
    endtask

    task automatic start_rec();
        @(negedge clk) rec = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // One falling edge; the next call's edge lands `ticks` ce ticks later.
    task automatic fall_in(input int ticks);
        @(negedge clk) cass_write = 1'b0;
        @(negedge clk) cass_write = 1'b1;
        repeat (ticks * ce_div - 2) @(negedge clk);
    endtask

    task automatic run_pulses(input int q[$]);
        foreach (q[i]) fall_in(q[i]);
        fall_in(4);
    endtask

    task automatic stop_and_wait(output bit ok);
        @(negedge clk) rec = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rec = 1'b0; cass_write = 1'b1; cass_motor_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (mem_we !== 1'b0)   begin failures++; $display("FAIL reset_we: got %b want 0", mem_we); end
        if (mem_addr !== BASE) begin failures++; $display("FAIL reset_addr: got %h want %h", mem_addr, BASE); end
        if (mem_dout !== 8'h0) begin failures++; $display("FAIL reset_dout: got %h want 00", mem_dout); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (length !== 24'd0)  begin failures++; $display("FAIL reset_length: got %0d want 0", length); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] hdr [16];
        logic [23:0] el;
        hdr = '{8'h43, 8'h36, 8'h34, 8'h2D, 8'h54, 8'h41, 8'h50, 8'h45,
                8'h2D, 8'h52, 8'h41, 8'h57, 8'h01, 8'h00, 8'h00, 8'h00};
        ce_div = 1; clear_rec();
        add_exp(400); add_exp(800);
        start_rec();
        run_pulses('{400, 800});
        stop_and_wait(ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_idle: busy stuck high"); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (rd(DOFF + i) !== exp_q[i]) begin failures++; $display("FAIL basic_data[%0d]: got %h want %h", i, rd(DOFF + i), exp_q[i]); end
        end
        checks++; if (length !== 24'd2) begin failures++; $display("FAIL basic_length: got %0d want 2", length); end
        checks++; if (nwr !== (HDR ? 22 : 2)) begin failures++; $display("FAIL basic_nwr: got %0d want %0d", nwr, HDR ? 22 : 2); end
        if (HDR) begin
            el = 24'd2;
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rd(i) !== hdr[i]) begin failures++; $display("FAIL hdr[%0d]: got %h want %h", i, rd(i), hdr[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd(16 + i) !== ((i < 3) ? el[8*i +: 8] : 8'h00)) begin
                    failures++; $display("FAIL len_field[%0d]: got %h", i, rd(16 + i));
                end
            end
        end
    endtask

    task automatic test_long();
        bit ok;
        ce_div = 1; clear_rec();
        add_exp(4000);
        start_rec();
        run_pulses('{4000});
        stop_and_wait(ok);
        checks++; if (!ok) begin failures++; $display("FAIL long_idle: busy stuck high"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd(DOFF + i) !== exp_q[i]) begin failures++; $display("FAIL long_data[%0d]: got %h want %h", i, rd(DOFF + i), exp_q[i]); end
        end
        checks++; if (length !== 24'd4) begin failures++; $display("FAIL long_length: got %0d want 4", length); end
    endtask

    task automatic test_boundary();
        bit ok;
        int q[$];
        ce_div = 1; clear_rec();
        q = '{5, 2047, 2048, 15, 16};   // glitch, largest short, smallest long, floor-to-1, 2
        foreach (q[i]) add_exp(q[i]);
        start_rec();
        run_pulses(q);
        stop_and_wait(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bnd_idle: busy stuck high"); end
        checks++; if (rd(DOFF) !== 8'h01) begin failures++; $display("FAIL glitch_byte: got %h want 01", rd(DOFF)); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (rd(DOFF + i) !== exp_q[i]) begin failures++; $display("FAIL bnd_data[%0d]: got %h want %h", i, rd(DOFF + i), exp_q[i]); end
        end
        checks++; if (length !== 24'(exp_q.size())) begin failures++; $display("FAIL bnd_length: got %0d want %0d", length, exp_q.size()); end
    endtask

    task automatic test_motor();
        bit ok;
        ce_div = 1; clear_rec();
        add_exp(400);   // 700 clocks, 300 with the motor off
        start_rec();
        @(negedge clk) cass_write = 1'b0;
        @(negedge clk) cass_write = 1'b1;
        repeat (198) @(negedge clk);
        cass_motor_n = 1'b1;
        repeat (300) @(negedge clk);
        cass_motor_n = 1'b0;
        repeat (200) @(negedge clk);
        fall_in(4);
        stop_and_wait(ok);
        checks++; if (!ok) begin failures++; $display("FAIL motor_idle: busy stuck high"); end
        checks++; if (rd(DOFF) !== exp_q[0]) begin failures++; $display("FAIL motor_byte: got %h want %h", rd(DOFF), exp_q[0]); end
    endtask

    task automatic test_overflow();
        bit ok;
        int q[$];
        ce_div = 1; clear_rec();
        for (int i = 0; i < 10; i++) q.push_back($urandom_range(60, 200));
        for (int i = 0; i < 8; i++) add_exp(q[i]);
        ack_en = 1'b0;
        start_rec();
        run_pulses(q);
        ack_en = 1'b1;
        stop_and_wait(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_idle: busy stuck high"); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (length !== 24'd8) begin failures++; $display("FAIL ovf_length: got %0d want 8", length); end
        checks++; if (nwr !== (HDR ? 28 : 8)) begin failures++; $display("FAIL ovf_nwr: got %0d want %0d", nwr, HDR ? 28 : 8); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd(DOFF + i) !== exp_q[i]) begin failures++; $display("FAIL ovf_data[%0d]: got %h want %h", i, rd(DOFF + i), exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit ok;
        int q[$];
        ce_div = 2; clear_rec();
        for (int i = 0; i < 6; i++) q.push_back($urandom_range(20, 400));
        q.push_back($urandom_range(2048, 3000));
        foreach (q[i]) add_exp(q[i]);
        start_rec();
        run_pulses(q);
        stop_and_wait(ok);
        ce_div = 1;
        checks++; if (!ok) begin failures++; $display("FAIL rnd_idle: busy stuck high"); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rnd_ovf_clear: got %b want 0", overflow); end
        checks++; if (length !== 24'(exp_q.size())) begin failures++; $display("FAIL rnd_length: got %0d want %0d", length, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (rd(DOFF + i) !== exp_q[i]) begin failures++; $display("FAIL rnd_data[%0d]: got %h want %h", i, rd(DOFF + i), exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ce_div = 1; clear_rec();
        start_rec();
        fall_in(100); fall_in(100); fall_in(100);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b want 1", busy); end
        #2 reset_n = 1'b0; rec = 1'b0;
        #1;
        checks += 6;
        if (mem_we !== 1'b0)   begin failures++; $display("FAIL mid_we: got %b want 0", mem_we); end
        if (mem_addr !== BASE) begin failures++; $display("FAIL mid_addr: got %h want %h", mem_addr, BASE); end
        if (mem_dout !== 8'h0) begin failures++; $display("FAIL mid_dout: got %h want 00", mem_dout); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL mid_busy0: got %b want 0", busy); end
        if (length !== 24'd0)  begin failures++; $display("FAIL mid_length: got %0d want 0", length); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL mid_ovf: got %b want 0", overflow); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_rec();
        add_exp(300); add_exp(500);
        start_rec();
        run_pulses('{300, 500});
        stop_and_wait(ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid2_idle: busy stuck high"); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rd(DOFF + i) !== exp_q[i]) begin failures++; $display("FAIL mid2_data[%0d]: got %h want %h", i, rd(DOFF + i), exp_q[i]); end
        end
        checks++; if (length !== 24'd2) begin failures++; $display("FAIL mid2_length: got %0d want 2", length); end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_long();
        test_boundary();
        test_motor();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
